status_wr_arbiter: RTL and testbench
====================================

STATUS_WR_ARBITER -- requirements
Module: status_wr_arbiter

Interface
REQ-001 Parameter NumStatusBits, default 2, width of every status bus.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 res_n  input  1  reset, synchronous, active-low.
REQ-004 alu_req  input  1  ALU requests a status write; held until alu_ack.
REQ-005 alu_status_in  input  NumStatusBits  status value offered by ALU.
REQ-006 alu_ack  output  1  one-cycle pulse, ALU write performed.
REQ-007 dec_req  input  1  decoder requests a status write; held until dec_ack.
REQ-008 dec_status_in  input  NumStatusBits  status value offered by decoder.
REQ-009 dec_ack  output  1  one-cycle pulse, decoder write performed.
REQ-010 status_cur  input  NumStatusBits  current status register contents (shadow source).
REQ-011 save_req  input  1  request copy of status_cur into shadow.
REQ-012 restore_req  input  1  request write-back of shadow into status register.
REQ-013 shadow_ack  output  1  one-cycle pulse, save or restore completed.
REQ-014 shadow_valid  output  1  shadow holds a saved, not yet restored value.
REQ-015 wr_en  output  1  status register write enable.
REQ-016 sel_stat_in_alu_decoder  output  1  1 = ALU source, 0 = decoder source.
REQ-017 alu_status  output  NumStatusBits  registered ALU-path write data.
REQ-018 dec_status  output  NumStatusBits  registered decoder-path write data.
REQ-019 busy  output  1  high while state is not IDLE.

Function
REQ-020 FSM states IDLE, WRITE; all outputs registered.
REQ-021 IDLE priority: restore_req > save_req > alu_req/dec_req arbitration.
REQ-022 Only alu_req or dec_req high in IDLE: grant it; both high: grant the one not granted last (round-robin).
REQ-023 ALU grant: latch alu_status_in into alu_status, sel=1, go WRITE.
REQ-024 Decoder grant: latch dec_status_in into dec_status, sel=0, go WRITE.
REQ-025 WRITE: wr_en=1 and matching ack=1 for exactly one cycle; next state IDLE.
REQ-026 Latency: request sampled at edge T, wr_en/ack high in cycle after T; max one write per 2 cycles.
REQ-027 Requester deasserts req in cycle after ack; req still high in IDLE then counts as new request.
REQ-028 Non-granted pending req remains pending, served on next IDLE cycle.
REQ-029 sel_stat_in_alu_decoder, alu_status, dec_status hold last values while wr_en=0.
REQ-030 last_grant flop updated only on ALU/decoder grant.

Reset
REQ-031 res_n low at edge: state IDLE, wr_en, acks, shadow_ack, busy, sel, alu_status, dec_status, shadow, shadow_valid all 0; last_grant=decoder (first contention goes to ALU).
REQ-032 Reset during WRITE: write aborted, no ack; requests still high re-arbitrated from IDLE after release.

Configuration
REQ-033 Macro STATUS_SHADOW_EN defined: save/restore logic present per REQ-034..REQ-036.
REQ-034 save_req in IDLE: shadow<=status_cur, shadow_valid<=1, shadow_ack pulse next cycle, no wr_en; save over valid shadow overwrites.
REQ-035 restore_req in IDLE with shadow_valid=1: dec_status<=shadow, sel=0, WRITE (wr_en pulse) with shadow_ack instead of dec_ack; shadow_valid<=0.
REQ-036 restore_req with shadow_valid=0: shadow_ack pulse next cycle, no wr_en, no state change.
REQ-037 Macro undefined: save_req/restore_req ignored, shadow_ack and shadow_valid constant 0, no shadow storage.

Verification
REQ-038 alu_req=1, alu_status_in=2'b10 at T -> cycle T+1: wr_en=1, sel=1, alu_status=2'b10, alu_ack=1; T+2 wr_en=0.
REQ-039 alu_req and dec_req both held from reset release -> grants ALU, DEC, ALU, DEC with wr_en pulses every 2 cycles.
REQ-040 dec_req=1, dec_status_in=2'b01, res_n=0 at edge where wr_en would rise -> wr_en=0, dec_ack=0, all outputs 0.
REQ-041 STATUS_SHADOW_EN: status_cur=2'b11, save_req -> shadow_ack, shadow_valid=1; later restore_req -> wr_en=1, sel=0, dec_status=2'b11, shadow_valid=0.
REQ-042 STATUS_SHADOW_EN: restore_req, alu_req, dec_req same cycle -> restore served first, then ALU.
REQ-043 Macro undefined: save_req=1 and restore_req=1 for 5 cycles -> shadow_ack=0, wr_en=0, busy=0.

Source files
------------

// File: rtl/status_wr_arbiter.sv
// Arbitrates ALU and decoder writes to the status register, round-robin under contention.
// Define STATUS_SHADOW_EN to add a one-entry save/restore shadow of the status register.
module status_wr_arbiter #(
  parameter int NumStatusBits = 2
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     alu_req,
  input  logic [NumStatusBits-1:0] alu_status_in,
  output logic                     alu_ack,
  input  logic                     dec_req,
  input  logic [NumStatusBits-1:0] dec_status_in,
  output logic                     dec_ack,
  input  logic [NumStatusBits-1:0] status_cur,
  input  logic                     save_req,
  input  logic                     restore_req,
  output logic                     shadow_ack,
  output logic                     shadow_valid,
  output logic                     wr_en,
  output logic                     sel_stat_in_alu_decoder,
  output logic [NumStatusBits-1:0] alu_status,
  output logic [NumStatusBits-1:0] dec_status,
  output logic                     busy
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0] state;
  logic       last_grant;  // 1 = ALU won the last contended/uncontended grant

`ifdef STATUS_SHADOW_EN
  logic [NumStatusBits-1:0] shadow;
`else
  logic unused;
  assign unused       = ^{save_req, restore_req, status_cur};
  assign shadow_ack   = 1'b0;
  assign shadow_valid = 1'b0;
`endif

  assign busy = state[0];

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state                   <= IDLE;
      wr_en                   <= 1'b0;
      alu_ack                 <= 1'b0;
      dec_ack                 <= 1'b0;
      sel_stat_in_alu_decoder <= 1'b0;
      alu_status              <= '0;
      dec_status              <= '0;
      last_grant              <= 1'b0;
`ifdef STATUS_SHADOW_EN
      shadow_ack              <= 1'b0;
      shadow_valid            <= 1'b0;
      shadow                  <= '0;
`endif
    end else begin
      wr_en   <= 1'b0;
      alu_ack <= 1'b0;
      dec_ack <= 1'b0;
`ifdef STATUS_SHADOW_EN
      shadow_ack <= 1'b0;
`endif
      if (state == WRITE) begin
        state <= IDLE;
      end else begin
`ifdef STATUS_SHADOW_EN
        if (restore_req) begin
          shadow_ack <= 1'b1;
          // Restore reuses the decoder data path; an empty shadow just acks.
          if (shadow_valid) begin
            dec_status              <= shadow;
            sel_stat_in_alu_decoder <= 1'b0;
            wr_en                   <= 1'b1;
            shadow_valid            <= 1'b0;
            state                   <= WRITE;
          end
        end else if (save_req) begin
          shadow       <= status_cur;
          shadow_valid <= 1'b1;
          shadow_ack   <= 1'b1;
        end else begin
`endif
          if (alu_req && (!dec_req || !last_grant)) begin
            alu_status              <= alu_status_in;
            sel_stat_in_alu_decoder <= 1'b1;
            wr_en                   <= 1'b1;
            alu_ack                 <= 1'b1;
            last_grant              <= 1'b1;
            state                   <= WRITE;
          end else if (dec_req) begin
            dec_status              <= dec_status_in;
            sel_stat_in_alu_decoder <= 1'b0;
            wr_en                   <= 1'b1;
            dec_ack                 <= 1'b1;
            last_grant              <= 1'b0;
            state                   <= WRITE;
          end
`ifdef STATUS_SHADOW_EN
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_status_wr_arbiter.sv
// Scoreboard bench for status_wr_arbiter: directed stimulus pushes expected writes/acks,
// a negedge monitor pops and compares every observed ack or write pulse.
module tb_status_wr_arbiter;
  localparam int W = 2;

  logic         clk, res_n;
  logic         alu_req, dec_req, save_req, restore_req;
  logic [W-1:0] alu_status_in, dec_status_in, status_cur;
  logic         alu_ack, dec_ack, shadow_ack, shadow_valid, wr_en, sel, busy;
  logic [W-1:0] alu_status, dec_status;

  typedef struct packed {
    logic         wr;
    logic         sel;
    logic [W-1:0] data;
    logic         aa, da, sa;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic hold  = 1'b0;
  logic prev_wr = 1'b0;

  status_wr_arbiter #(.NumStatusBits(W)) dut (
    .clk(clk), .res_n(res_n),
    .alu_req(alu_req), .alu_status_in(alu_status_in), .alu_ack(alu_ack),
    .dec_req(dec_req), .dec_status_in(dec_status_in), .dec_ack(dec_ack),
    .status_cur(status_cur), .save_req(save_req), .restore_req(restore_req),
    .shadow_ack(shadow_ack), .shadow_valid(shadow_valid),
    .wr_en(wr_en), .sel_stat_in_alu_decoder(sel),
    .alu_status(alu_status), .dec_status(dec_status), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic wr, input logic s, input logic [W-1:0] d,
                      input logic aa, input logic da, input logic sa);
    exp_t e;
    e.wr = wr; e.sel = wr ? s : 1'b0; e.data = wr ? d : '0;
    e.aa = aa; e.da = da; e.sa = sa;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #3;
      if (q.size() == 0 && !alu_req && !dec_req && !save_req && !restore_req && !busy) done = 1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s_timeout actual=pending%0d required=pending0", name, q.size());
    end
  endtask

  // Monitor: every write pulse or ack must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t o, e;
    if (res_n && (wr_en || alu_ack || dec_ack || shadow_ack)) begin
      o.wr = wr_en; o.sel = wr_en ? sel : 1'b0;
      o.data = wr_en ? (sel ? alu_status : dec_status) : '0;
      o.aa = alu_ack; o.da = dec_ack; o.sa = shadow_ack;
      if (q.size() == 0) begin
        chk("unexpected_event", 16'(o), 16'h0);
      end else begin
        e = q.pop_front();
        chk("write_event", 16'(o), 16'(e));
      end
    end
    if (wr_en && prev_wr) chk("wr_en_back_to_back", 16'd1, 16'd0);
    prev_wr = wr_en;
  end

  // Requester behaviour: drop a request once its ack is seen.
  initial forever begin
    @(posedge clk); #2;
    if (!hold) begin
      if (alu_ack) alu_req = 1'b0;
      if (dec_ack) dec_req = 1'b0;
      if (shadow_ack) begin save_req = 1'b0; restore_req = 1'b0; end
    end
  end

  initial begin
    res_n = 1'b0; alu_req = 0; dec_req = 0; save_req = 0; restore_req = 0;
    alu_status_in = '0; dec_status_in = '0; status_cur = '0;
    repeat (3) @(posedge clk); #1;
    chk("reset_state", 16'({wr_en, busy, sel, alu_status, dec_status, alu_ack, dec_ack,
                            shadow_ack, shadow_valid}), 16'h0);
    res_n = 1'b1;

    // Single ALU write: exact latency and one-cycle pulse
    @(posedge clk); #1;
    push(1, 1, 2'b10, 1, 0, 0);
    alu_req = 1; alu_status_in = 2'b10;
    @(posedge clk); #1;
    chk("alu_latency", 16'({wr_en, sel, alu_status, alu_ack}), 16'b11101);
    @(posedge clk); #1;
    chk("alu_wr_drop", 16'(wr_en), 16'h0);
    wait_idle("alu_single");

    push(1, 0, 2'b01, 0, 1, 0);
    dec_req = 1; dec_status_in = 2'b01;
    wait_idle("dec_single");
    chk("hold_after_write", 16'({sel, dec_status}), 16'b001);

    // Contention after decoder grant: ALU first, pending decoder served next
    push(1, 1, 2'b11, 1, 0, 0); push(1, 0, 2'b10, 0, 1, 0);
    alu_req = 1; alu_status_in = 2'b11; dec_req = 1; dec_status_in = 2'b10;
    wait_idle("contend1");
    push(1, 1, 2'b01, 1, 0, 0); push(1, 0, 2'b00, 0, 1, 0);
    alu_req = 1; alu_status_in = 2'b01; dec_req = 1; dec_status_in = 2'b00;
    wait_idle("contend2");

    // Both held from reset release: ALU, DEC, ALU, DEC every 2 cycles
    @(posedge clk); #1;
    hold = 1; res_n = 0;
    alu_req = 1; dec_req = 1; alu_status_in = 2'b01; dec_status_in = 2'b10;
    repeat (2) @(posedge clk); #1;
    push(1, 1, 2'b01, 1, 0, 0); push(1, 0, 2'b10, 0, 1, 0);
    push(1, 1, 2'b01, 1, 0, 0); push(1, 0, 2'b10, 0, 1, 0);
    res_n = 1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rr_wr_cycle%0d", i), 16'(wr_en), 16'((i % 2) == 0));
    end
    alu_req = 0; dec_req = 0; hold = 0;
    wait_idle("round_robin");

    // Reset on the edge where the decoder write would start
    @(posedge clk); #1;
    dec_req = 1; dec_status_in = 2'b01; res_n = 0;
    @(posedge clk); #1;
    chk("reset_abort", 16'({wr_en, dec_ack, busy, sel, alu_status, dec_status}), 16'h0);
    push(1, 0, 2'b01, 0, 1, 0);
    res_n = 1;
    wait_idle("rearb_after_reset");

`ifdef STATUS_SHADOW_EN
    status_cur = 2'b11;
    push(0, 0, '0, 0, 0, 1);
    save_req = 1;
    wait_idle("save");
    chk("shadow_valid_set", 16'(shadow_valid), 16'h1);
    status_cur = 2'b00;
    push(1, 0, 2'b11, 0, 0, 1);
    restore_req = 1;
    wait_idle("restore");
    chk("restore_state", 16'({shadow_valid, dec_status}), 16'b011);

    push(0, 0, '0, 0, 0, 1);
    restore_req = 1;
    wait_idle("restore_empty");

    status_cur = 2'b01;
    push(0, 0, '0, 0, 0, 1);
    save_req = 1;
    wait_idle("save2");
    push(1, 0, 2'b01, 0, 0, 1); push(1, 1, 2'b10, 1, 0, 0); push(1, 0, 2'b11, 0, 1, 0);
    restore_req = 1; alu_req = 1; alu_status_in = 2'b10; dec_req = 1; dec_status_in = 2'b11;
    wait_idle("restore_priority");
`else
    @(posedge clk); #1;
    save_req = 1; restore_req = 1; status_cur = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("shadow_off_cycle%0d", i),
          16'({shadow_ack, shadow_valid, wr_en, busy}), 16'h0);
    end
    save_req = 0; restore_req = 0;
`endif

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drained", 16'(q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
